// File: rtl/hls_arb_pkg.sv
// Shared types and constants for the two-stream packet arbiter in front of the HLS core.
package hls_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 16;
    // Payload length lives in the low bits of the header word.
    localparam int LEN_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } arb_state_e;

    // Two-way round-robin pick; last is the index of the previous owner.
    function automatic logic [1:0] rr_pick(input logic [1:0] elig, input logic last);
        logic [1:0] p;
        p = 2'b00;
        case (elig)
            2'b01:   p = 2'b01;
            2'b10:   p = 2'b10;
            2'b11:   p = last ? 2'b01 : 2'b10;
            default: p = 2'b00;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/hls_stream_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational pick plus the last-owner register.
import hls_arb_pkg::*;

module rr_arb2 (
    input  logic       bus_clk,
    input  logic       srst,
    input  logic [1:0] eligible,
    input  logic       update,
    output logic [1:0] pick
);

    logic last_grant_r;

    // Pick the eligible requester that did not own the core last.
    always_comb begin
        pick = rr_pick(eligible, last_grant_r);
    end

    // Remember the owner of each new grant; reset favours requester 0 first.
    always_ff @(posedge bus_clk) begin
        if (srst) begin
            last_grant_r <= 1'b1;
        end else if (update && (pick != 2'b00)) begin
            last_grant_r <= pick[1];
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/hls_stream_arbiter.sv
// Packet-level arbiter sharing the HLS core ap_fifo input between two host streams.
import hls_arb_pkg::*;

module hls_stream_arbiter #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              bus_clk,
    input  logic              srst,
    input  logic [DATA_W-1:0] req0_dout,
    input  logic              req0_empty,
    input  logic              req0_open,
    output logic              req0_rd_en,
    input  logic [DATA_W-1:0] req1_dout,
    input  logic              req1_empty,
    input  logic              req1_open,
    output logic              req1_rd_en,
    output logic [DATA_W-1:0] in_r_dout,
    output logic              in_r_empty_n,
    input  logic              in_r_read,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              pkt_done,
    output logic              abort
);

    arb_state_e        state_r, state_nxt_s;
    logic [1:0]        grant_r, grant_nxt_s;
    logic              empty_n_r, empty_n_nxt_s;
    logic [LEN_W-1:0]  fetch_rem_r, fetch_rem_nxt_s;
    logic              pkt_done_r, pkt_done_nxt_s;
    logic              abort_r, abort_nxt_s;
    logic              rd_en_s;
    logic              arb_update_s;
    logic [1:0]        eligible_s;
    logic [1:0]        pick_s;
    logic              open_g_s;
    logic              empty_g_s;
    logic [DATA_W-1:0] dout_g_s;
    logic              consume_s;
    logic [LEN_W-1:0]  len_s;

    assign eligible_s = {req1_open & ~req1_empty, req0_open & ~req0_empty};

    rr_arb2 u_rr_arb2 (
        .bus_clk  (bus_clk),
        .srst     (srst),
        .eligible (eligible_s),
        .update   (arb_update_s),
        .pick     (pick_s)
    );

    // Route the granted requester's FIFO signals; no owner looks closed and empty.
    always_comb begin
        open_g_s  = 1'b0;
        empty_g_s = 1'b1;
        dout_g_s  = {DATA_W{1'b0}};
        if (grant_r[1]) begin
            open_g_s  = req1_open;
            empty_g_s = req1_empty;
            dout_g_s  = req1_dout;
        end else if (grant_r[0]) begin
            open_g_s  = req0_open;
            empty_g_s = req0_empty;
            dout_g_s  = req0_dout;
        end else begin
            open_g_s  = 1'b0;
            empty_g_s = 1'b1;
            dout_g_s  = {DATA_W{1'b0}};
        end
    end

    assign consume_s = in_r_read & empty_n_r;
    assign len_s     = dout_g_s[LEN_LSB +: LEN_W];

    // Next-state, fetch strobe and flag updates; a finished packet wins over an owner close.
    always_comb begin
        state_nxt_s     = state_r;
        grant_nxt_s     = grant_r;
        empty_n_nxt_s   = empty_n_r;
        fetch_rem_nxt_s = fetch_rem_r;
        pkt_done_nxt_s  = 1'b0;
        abort_nxt_s     = 1'b0;
        rd_en_s         = 1'b0;
        arb_update_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                empty_n_nxt_s = 1'b0;
                if (pick_s != 2'b00) begin
                    grant_nxt_s  = pick_s;
                    state_nxt_s  = ST_HDR;
                    arb_update_s = 1'b1;
                end else begin
                    grant_nxt_s  = 2'b00;
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (consume_s && (len_s == {LEN_W{1'b0}})) begin
                    empty_n_nxt_s   = 1'b0;
                    fetch_rem_nxt_s = {LEN_W{1'b0}};
                    pkt_done_nxt_s  = 1'b1;
                    grant_nxt_s     = 2'b00;
                    state_nxt_s     = ST_IDLE;
                end else if (!open_g_s) begin
                    empty_n_nxt_s   = 1'b0;
                    fetch_rem_nxt_s = {LEN_W{1'b0}};
                    abort_nxt_s     = 1'b1;
                    grant_nxt_s     = 2'b00;
                    state_nxt_s     = ST_IDLE;
                end else if (consume_s) begin
                    // Header taken: the bubble cycle that follows issues the first payload fetch.
                    empty_n_nxt_s   = 1'b0;
                    fetch_rem_nxt_s = len_s;
                    state_nxt_s     = ST_PAYLOAD;
                end else begin
                    rd_en_s = !empty_g_s && !empty_n_r;
                    if (rd_en_s) begin
                        empty_n_nxt_s = 1'b1;
                    end else begin
                        empty_n_nxt_s = empty_n_r;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (consume_s && (fetch_rem_r == {LEN_W{1'b0}})) begin
                    empty_n_nxt_s  = 1'b0;
                    pkt_done_nxt_s = 1'b1;
                    grant_nxt_s    = 2'b00;
                    state_nxt_s    = ST_IDLE;
                end else if (!open_g_s) begin
                    empty_n_nxt_s   = 1'b0;
                    fetch_rem_nxt_s = {LEN_W{1'b0}};
                    abort_nxt_s     = 1'b1;
                    grant_nxt_s     = 2'b00;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    rd_en_s = !empty_g_s && (fetch_rem_r != {LEN_W{1'b0}}) &&
                              (in_r_read || !empty_n_r);
                    if (rd_en_s) begin
                        fetch_rem_nxt_s = fetch_rem_r - LEN_W'(1);
                        empty_n_nxt_s   = 1'b1;
                    end else if (in_r_read) begin
                        empty_n_nxt_s   = 1'b0;
                    end else begin
                        empty_n_nxt_s   = empty_n_r;
                    end
                end
            end
            default: begin
                empty_n_nxt_s   = 1'b0;
                fetch_rem_nxt_s = {LEN_W{1'b0}};
                grant_nxt_s     = 2'b00;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; srst returns everything to idle, even mid-packet.
    always_ff @(posedge bus_clk) begin
        if (srst) begin
            state_r     <= ST_IDLE;
            grant_r     <= 2'b00;
            empty_n_r   <= 1'b0;
            fetch_rem_r <= {LEN_W{1'b0}};
            pkt_done_r  <= 1'b0;
            abort_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            grant_r     <= grant_nxt_s;
            empty_n_r   <= empty_n_nxt_s;
            fetch_rem_r <= fetch_rem_nxt_s;
            pkt_done_r  <= pkt_done_nxt_s;
            abort_r     <= abort_nxt_s;
        end
    end

    assign req0_rd_en   = rd_en_s & grant_r[0];
    assign req1_rd_en   = rd_en_s & grant_r[1];
    assign in_r_dout    = dout_g_s;
    assign in_r_empty_n = empty_n_r;
    assign grant        = grant_r;
    assign busy         = (state_r != ST_IDLE);
    assign pkt_done     = pkt_done_r;
    assign abort        = abort_r;

endmodule

// File: tb/tb_hls_stream_arbiter.sv
// Scoreboard bench for hls_stream_arbiter with behavioural FIFO and core models.
module tb_hls_stream_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  gnt;
    } sb_item_t;

    logic        bus_clk    = 1'b0;
    logic        srst       = 1'b1;
    logic [31:0] req0_dout  = 32'h0;
    logic        req0_empty = 1'b1;
    logic        req0_open  = 1'b1;
    logic        req0_rd_en;
    logic [31:0] req1_dout  = 32'h0;
    logic        req1_empty = 1'b1;
    logic        req1_open  = 1'b1;
    logic        req1_rd_en;
    logic [31:0] in_r_dout;
    logic        in_r_empty_n;
    logic        in_r_read  = 1'b0;
    logic [1:0]  grant;
    logic        busy;
    logic        pkt_done;
    logic        abort;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    sb_item_t    sb[$];
    sb_item_t    exp_item;
    int          cons_cyc[$];
    int total = 0, bad = 0;
    int cyc = 0, cons_cnt = 0, done_cnt = 0, abort_cnt = 0, rd0_cnt = 0, rd1_cnt = 0;

    hls_stream_arbiter dut (
        .bus_clk      (bus_clk),
        .srst         (srst),
        .req0_dout    (req0_dout),
        .req0_empty   (req0_empty),
        .req0_open    (req0_open),
        .req0_rd_en   (req0_rd_en),
        .req1_dout    (req1_dout),
        .req1_empty   (req1_empty),
        .req1_open    (req1_open),
        .req1_rd_en   (req1_rd_en),
        .in_r_dout    (in_r_dout),
        .in_r_empty_n (in_r_empty_n),
        .in_r_read    (in_r_read),
        .grant        (grant),
        .busy         (busy),
        .pkt_done     (pkt_done),
        .abort        (abort)
    );

    always #5 bus_clk = ~bus_clk;

    // Standard-read-latency FIFO models; a closed stream is flushed.
    always @(posedge bus_clk) begin
        cyc <= cyc + 1;
        if (!req0_open) begin
            q0.delete();
            req0_empty <= 1'b1;
        end else begin
            if (req0_rd_en && q0.size() > 0) req0_dout <= q0.pop_front();
            req0_empty <= (q0.size() == 0);
        end
        if (!req1_open) begin
            q1.delete();
            req1_empty <= 1'b1;
        end else begin
            if (req1_rd_en && q1.size() > 0) req1_dout <= q1.pop_front();
            req1_empty <= (q1.size() == 0);
        end
    end

    // Core-side monitor: scoreboard compare on every consumed word, read-strobe guard.
    always @(negedge bus_clk) begin
        if (pkt_done) done_cnt = done_cnt + 1;
        if (abort) abort_cnt = abort_cnt + 1;
        if (req0_rd_en) rd0_cnt = rd0_cnt + 1;
        if (req1_rd_en) rd1_cnt = rd1_cnt + 1;
        total = total + 1;
        if ((req0_rd_en && !(grant == 2'b01 && req0_open)) ||
            (req1_rd_en && !(grant == 2'b10 && req1_open))) begin
            bad = bad + 1;
            $display("FAIL rd_guard: rd_en=%b%b grant=%b open=%b%b required no read", req1_rd_en,
                     req0_rd_en, grant, req1_open, req0_open);
        end
        if (in_r_empty_n && in_r_read) begin
            total = total + 1;
            if (sb.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_word: got %h grant=%b required none", in_r_dout, grant);
            end else begin
                exp_item = sb.pop_front();
                if ({in_r_dout, grant} !== {exp_item.data, exp_item.gnt}) begin
                    bad = bad + 1;
                    $display("FAIL word: got %h grant=%b required %h grant=%b", in_r_dout, grant,
                             exp_item.data, exp_item.gnt);
                end
            end
            cons_cnt = cons_cnt + 1;
            cons_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic load(input int port, input logic [15:0] hi, input int n, input logic [31:0] base);
        logic [31:0] w;
        w = {hi, 16'(n)};
        if (port == 0) q0.push_back(w); else q1.push_back(w);
        for (int i = 1; i <= n; i++) begin
            w = base + 32'(i);
            if (port == 0) q0.push_back(w); else q1.push_back(w);
        end
    endtask

    task automatic expect_pkt(input int port, input logic [15:0] hi, input int n,
                              input logic [31:0] base, input int nexp);
        sb_item_t it;
        it.gnt  = (port == 0) ? 2'b01 : 2'b10;
        it.data = {hi, 16'(n)};
        if (nexp > 0) sb.push_back(it);
        for (int i = 1; i <= n && i < nexp; i++) begin
            it.data = base + 32'(i);
            sb.push_back(it);
        end
    endtask

    task automatic wait_cons(input int target, input int budget);
        int k;
        k = 0;
        while (cons_cnt < target && k < budget) begin
            tick();
            k++;
        end
        total = total + 1;
        if (cons_cnt < target) begin
            bad = bad + 1;
            $display("FAIL wait_cons_timeout: consumed %0d required %0d", cons_cnt, target);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < budget) begin
            tick();
            k++;
        end
        total = total + 1;
        if (sb.size() != 0 || busy) begin
            bad = bad + 1;
            $display("FAIL wait_idle_timeout: pending=%0d busy=%b required 0/0", sb.size(), busy);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        srst = 1'b1;
        repeat (3) tick();
        total = total + 1;
        if ({grant, in_r_empty_n, busy, pkt_done, abort, req0_rd_en, req1_rd_en} !== 8'b0) begin
            bad = bad + 1;
            $display("FAIL reset_outputs: got g=%b en=%b b=%b d=%b a=%b rd=%b%b required all 0",
                     grant, in_r_empty_n, busy, pkt_done, abort, req1_rd_en, req0_rd_en);
        end
        srst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int d0, c0;
        d0 = done_cnt;
        c0 = cons_cnt;
        cons_cyc.delete();
        in_r_read = 1'b1;
        load(0, 16'h0000, 3, 32'hA0);
        expect_pkt(0, 16'h0000, 3, 32'hA0, 4);
        wait_idle(100);
        total = total + 1;
        if (cons_cnt - c0 !== 4) begin
            bad = bad + 1;
            $display("FAIL single_count: got %0d words required 4", cons_cnt - c0);
        end
        total = total + 1;
        if (cons_cyc.size() != 4) begin
            bad = bad + 1;
            $display("FAIL single_timing: got %0d samples required 4", cons_cyc.size());
        end else if (cons_cyc[1] - cons_cyc[0] != 2 || cons_cyc[3] - cons_cyc[1] != 2) begin
            bad = bad + 1;
            $display("FAIL single_timing: got gaps %0d,%0d required 2,2", cons_cyc[1] - cons_cyc[0],
                     cons_cyc[3] - cons_cyc[1]);
        end
        total = total + 1;
        if (done_cnt - d0 !== 1 || grant !== 2'b00) begin
            bad = bad + 1;
            $display("FAIL single_done: got done=%0d grant=%b required 1 00", done_cnt - d0, grant);
        end
    endtask

    task automatic test_zero_len();
        int d0, r0;
        d0 = done_cnt;
        r0 = rd1_cnt;
        load(1, 16'hABCD, 0, 32'h0);
        expect_pkt(1, 16'hABCD, 0, 32'h0, 1);
        wait_idle(100);
        total = total + 1;
        if (done_cnt - d0 !== 1 || rd1_cnt - r0 !== 1 || grant !== 2'b00) begin
            bad = bad + 1;
            $display("FAIL zero_len: got done=%0d rd1=%0d grant=%b required 1 1 00",
                     done_cnt - d0, rd1_cnt - r0, grant);
        end
    endtask

    task automatic test_round_robin();
        int d0, c0;
        d0 = done_cnt;
        c0 = cons_cnt;
        load(0, 16'h1111, 2, 32'hB0);
        load(0, 16'h2222, 2, 32'hB2);
        load(1, 16'h3333, 2, 32'hC0);
        load(1, 16'h4444, 2, 32'hC2);
        expect_pkt(0, 16'h1111, 2, 32'hB0, 3);
        expect_pkt(1, 16'h3333, 2, 32'hC0, 3);
        expect_pkt(0, 16'h2222, 2, 32'hB2, 3);
        expect_pkt(1, 16'h4444, 2, 32'hC2, 3);
        wait_idle(300);
        total = total + 1;
        if (done_cnt - d0 !== 4 || cons_cnt - c0 !== 12) begin
            bad = bad + 1;
            $display("FAIL rr_counts: got done=%0d words=%0d required 4 12", done_cnt - d0,
                     cons_cnt - c0);
        end
    endtask

    task automatic test_stall();
        int d0, c0, r0, rs;
        d0 = done_cnt;
        c0 = cons_cnt;
        r0 = rd0_cnt;
        load(0, 16'h5555, 5, 32'hD0);
        expect_pkt(0, 16'h5555, 5, 32'hD0, 6);
        wait_cons(c0 + 3, 100);
        in_r_read = 1'b0;
        rs = rd0_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            total = total + 1;
            if (in_r_dout !== 32'hD3 || in_r_empty_n !== 1'b1) begin
                bad = bad + 1;
                $display("FAIL stall_hold: got %h en=%b required 000000d3 en=1", in_r_dout,
                         in_r_empty_n);
            end
        end
        total = total + 1;
        if (rd0_cnt !== rs) begin
            bad = bad + 1;
            $display("FAIL stall_rd: got %0d extra reads required 0", rd0_cnt - rs);
        end
        in_r_read = 1'b1;
        wait_idle(100);
        total = total + 1;
        if (done_cnt - d0 !== 1 || rd0_cnt - r0 !== 6) begin
            bad = bad + 1;
            $display("FAIL stall_done: got done=%0d reads=%0d required 1 6", done_cnt - d0,
                     rd0_cnt - r0);
        end
    endtask

    task automatic test_abort();
        int d0, a0, c0;
        d0 = done_cnt;
        a0 = abort_cnt;
        c0 = cons_cnt;
        load(0, 16'h8888, 8, 32'hE0);
        expect_pkt(0, 16'h8888, 8, 32'hE0, 3);
        wait_cons(c0 + 3, 100);
        in_r_read = 1'b0;
        req0_open = 1'b0;
        load(1, 16'h0F0F, 1, 32'hF0);
        expect_pkt(1, 16'h0F0F, 1, 32'hF0, 2);
        tick();
        total = total + 1;
        if (abort !== 1'b1 || grant !== 2'b00 || in_r_empty_n !== 1'b0 || busy !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL abort_state: got a=%b g=%b en=%b b=%b required 1 00 0 0", abort, grant,
                     in_r_empty_n, busy);
        end
        req0_open = 1'b1;
        in_r_read = 1'b1;
        wait_idle(100);
        total = total + 1;
        if (abort_cnt - a0 !== 1 || done_cnt - d0 !== 1) begin
            bad = bad + 1;
            $display("FAIL abort_counts: got abort=%0d done=%0d required 1 1", abort_cnt - a0,
                     done_cnt - d0);
        end
    endtask

    task automatic test_srst();
        int d0, c0;
        c0 = cons_cnt;
        load(0, 16'h4444, 4, 32'h60);
        expect_pkt(0, 16'h4444, 4, 32'h60, 2);
        wait_cons(c0 + 2, 100);
        srst = 1'b1;
        in_r_read = 1'b0;
        req0_open = 1'b0;
        tick();
        total = total + 1;
        if ({grant, in_r_empty_n, busy, pkt_done, abort, req0_rd_en, req1_rd_en} !== 8'b0 ||
            in_r_dout !== 32'h0) begin
            bad = bad + 1;
            $display("FAIL srst_outputs: got g=%b en=%b b=%b d=%b a=%b dout=%h required zeros",
                     grant, in_r_empty_n, busy, pkt_done, abort, in_r_dout);
        end
        srst = 1'b0;
        req0_open = 1'b1;
        tick();
        d0 = done_cnt;
        load(0, 16'h0101, 1, 32'h70);
        load(1, 16'h0202, 1, 32'h80);
        expect_pkt(0, 16'h0101, 1, 32'h70, 2);
        expect_pkt(1, 16'h0202, 1, 32'h80, 2);
        in_r_read = 1'b1;
        wait_idle(100);
        total = total + 1;
        if (done_cnt - d0 !== 2) begin
            bad = bad + 1;
            $display("FAIL srst_after: got done=%0d required 2", done_cnt - d0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_round_robin();
        test_stall();
        test_abort();
        test_srst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
